// File: rtl/mac_accumulator.sv
// Two-stage streaming multiply-accumulate: registered product, then bias-seeded accumulate.
// One saturated 2*WORD_SIZE dot-product word is emitted per VEC_LEN accepted elements.
module mac_accumulator #(
  parameter int WORD_SIZE = 16,
  parameter int VEC_LEN   = 8,
  parameter int W_FRAC    = 8,
  parameter int GUARD     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          DI_valid,
  input  logic signed [WORD_SIZE-1:0]   DI,
  input  logic signed [WORD_SIZE-1:0]   W,
  input  logic signed [WORD_SIZE-1:0]   BIAS,
  output logic                          DO_valid,
  output logic signed [2*WORD_SIZE-1:0] DO
);
  localparam int PW    = 2 * WORD_SIZE;
  localparam int ACC_W = PW + GUARD;
  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  logic [CNT_W-1:0]        cnt;
  logic                    p_vld, p_first, p_last;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] bias_ext, acc, acc_next;
  logic signed [PW-1:0]    sat_val;

  // Stage 1: product register plus vector-position flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      p_vld    <= 1'b0;
      p_first  <= 1'b0;
      p_last   <= 1'b0;
      prod     <= '0;
      bias_ext <= '0;
    end else begin
      p_vld <= DI_valid;
      if (DI_valid) begin
        prod    <= DI * W;
        p_first <= (cnt == '0);
        p_last  <= (cnt == CNT_LAST);
        if (cnt == '0)
          bias_ext <= {{(ACC_W-WORD_SIZE){BIAS[WORD_SIZE-1]}}, BIAS} << W_FRAC;
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // First element reloads from bias so back-to-back vectors need no bubble
  always_comb begin
    acc_next = (p_first ? bias_ext : acc) + {{GUARD{prod[PW-1]}}, prod};
    sat_val  = acc_next[PW-1:0];
    if (acc_next[ACC_W-1:PW-1] != {(GUARD+1){acc_next[ACC_W-1]}})
      sat_val = acc_next[ACC_W-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  // Stage 2: accumulate, emit saturated result on the last element
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      DO       <= '0;
      DO_valid <= 1'b0;
    end else begin
      DO_valid <= 1'b0;
      if (p_vld) begin
        acc <= acc_next;
        if (p_last) begin
          DO       <= sat_val;
          DO_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and random checks of mac_accumulator against a vector-level arithmetic model.
module tb_mac_accumulator;
  localparam int WS = 16;
  localparam int VL = 4;
  localparam int WF = 8;

  logic                 clk, rst, DI_valid, DO_valid;
  logic signed [WS-1:0] DI, W, BIAS;
  logic signed [2*WS-1:0] DO;

  int errors = 0;
  int checks = 0;

  // model state: products of the open vector, its bias, one pending result
  longint prods[$];
  longint bias_first;
  logic   pend;
  longint pend_val;
  logic   exp_vld;
  logic [2*WS-1:0] exp_do;

  mac_accumulator #(.WORD_SIZE(WS), .VEC_LEN(VL), .W_FRAC(WF), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .DI_valid(DI_valid), .DI(DI), .W(W), .BIAS(BIAS),
    .DO_valid(DO_valid), .DO(DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WS-1:0] sat(input longint s);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[2*WS-1:0];
  endfunction

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [WS-1:0] di, input logic [WS-1:0] w, input logic [WS-1:0] b);
    longint s;
    rst = r; DI_valid = v; DI = di; W = w; BIAS = b;
    @(posedge clk);
    if (r) begin
      prods.delete();
      pend = 1'b0; exp_vld = 1'b0; exp_do = '0;
    end else begin
      exp_vld = pend;
      if (pend) exp_do = sat(pend_val);
      pend = 1'b0;
      if (v) begin
        if (prods.size() == 0) bias_first = longint'($signed(b)) * (longint'(1) << WF);
        prods.push_back(longint'($signed(di)) * longint'($signed(w)));
        if (prods.size() == VL) begin
          s = bias_first;
          foreach (prods[i]) s += prods[i];
          pend = 1'b1; pend_val = s;
          prods.delete();
        end
      end
    end
    @(negedge clk);
    checks++;
    assert (DO_valid === exp_vld) else begin
      errors++;
      $error("FAIL %s DO_valid observed=%0b expected=%0b", tag, DO_valid, exp_vld);
    end
    checks++;
    assert (DO === exp_do) else begin
      errors++;
      $error("FAIL %s DO observed=%h expected=%h", tag, DO, exp_do);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [6:0] gap_pat;
    pend = 1'b0; exp_vld = 1'b0; exp_do = '0; bias_first = 0;
    rst = 1'b1; DI_valid = 1'b0; DI = '0; W = '0; BIAS = '0;
    @(negedge clk);

    // reset with DI_valid asserted: elements dropped, outputs stay zero
    step("rst_vld", 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0100);
    step("rst_vld", 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0100);
    idle("rst_after", 4);

    for (int i = 0; i < VL; i++) step("basic", 1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000);
    idle("basic_out", 3);

    for (int i = 0; i < VL; i++)
      step("bias", 1'b0, 1'b1, 16'h0100, 16'h0100, (i == 0) ? 16'h0100 : 16'h7777);
    idle("bias_out", 3);

    for (int i = 0; i < VL; i++) step("sat_pos", 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000);
    idle("sat_pos_out", 2);
    for (int i = 0; i < VL; i++) step("sat_neg", 1'b0, 1'b1, 16'h8000, 16'h7FFF, 16'h0000);
    idle("sat_neg_out", 2);

    gap_pat = 7'b1100101;  // applied LSB first: 1,0,1,0,0,1,1
    for (int i = 0; i < 7; i++) step("gap_a", 1'b0, gap_pat[i], 16'h0001, 16'h0001, 16'h0000);
    for (int i = 0; i < VL; i++) step("b2b_b", 1'b0, 1'b1, 16'h0002, 16'h0003, 16'h0000);
    idle("b2b_out", 3);

    step("midrst", 1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000);
    step("midrst", 1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000);
    step("midrst", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < VL; i++) step("midrst_new", 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0000);
    idle("midrst_out", 3);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
           16'($urandom), 16'($urandom), 16'($urandom));
    idle("rand_flush", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
